// File: rtl/bus_rd_pack.sv
// Read-data packer: gathers 8/16/32/64-bit external read beats into one
// 64-bit word with per-lane valid mask; big-endian lanes if BUS_RD_PACK_BIGEND_EN.
//
// Ports:
//   sys_clk, reset       clock, async active-high reset
//   start, mws, ba       begin assembly: device width code, start byte
//   ack, xd              beat strobe and external data (low wb bytes used)
//   abort                cancel assembly in progress
//   busy, done           assembling / one-cycle completion pulse
//   dout, bval           assembled word and byte-lane valid mask
//   beat                 beats captured (saturates at 7)
module bus_rd_pack #(
  parameter int DW   = 64,
  parameter int ACKQ = 0
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    mws,
  input  logic [2:0]    ba,
  input  logic          ack,
  input  logic [63:0]   xd,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] dout,
  output logic [7:0]    bval,
  output logic [2:0]    beat
);

  generate
    if (DW != 64) begin : g_dw_chk
      $error("bus_rd_pack: DW must be 64");
    end
  endgenerate

`ifdef BUS_RD_PACK_BIGEND_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t state, state_n;

  logic [1:0]    mws_r;
  logic [3:0]    lane;
  logic [3:0]    wb;
  logic [3:0]    lane_nx;
  logic [2:0]    lane0;
  logic          cap;
  logic [DW-1:0] dout_n;
  logic [7:0]    bval_n;

  // Capture event, optionally one cycle behind ack.
  // The delayed strobe is dropped on abort and never armed outside FILL.
  generate
    if (ACKQ == 1) begin : g_ackq
      logic ack_q;
      always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) ack_q <= 1'b0;
        else       ack_q <= ack & (state == FILL) & ~abort;
      end
      assign cap = ack_q;
    end else begin : g_ack
      assign cap = ack;
    end
  endgenerate

  assign wb      = 4'd1 << mws_r;
  assign lane_nx = lane + wb;
  assign busy    = (state == FILL);
  assign done    = (state == DONE);

  // Align the start byte down to the device width.
  always_comb begin
    lane0 = ba;
    case (mws)
      2'd0:    lane0 = ba;
      2'd1:    lane0 = {ba[2:1], 1'b0};
      2'd2:    lane0 = {ba[2], 2'b00};
      default: lane0 = 3'd0;
    endcase
  end

  // Merge the current beat into lanes lane..lane+wb-1.
  always_comb begin
    dout_n = dout;
    bval_n = bval;
    for (int k = 0; k < 8; k++) begin
      if (k >= int'(lane) && k < int'(lane_nx)) begin
        dout_n[8*(BE ? 7-k : k) +: 8] = xd[8*(k-int'(lane)) +: 8];
        bval_n[BE ? 7-k : k]          = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = FILL;
      FILL: begin
        if (abort)                            state_n = IDLE;
        else if (cap && lane_nx == 4'd8)      state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      mws_r <= 2'd0;
      lane  <= 4'd0;
      dout  <= '0;
      bval  <= 8'd0;
      beat  <= 3'd0;
    end else begin
      if (state == IDLE && start) begin
        mws_r <= mws;
        lane  <= {1'b0, lane0};
        bval  <= 8'd0;
        beat  <= 3'd0;
      end else if (state == FILL && !abort && cap) begin
        dout <= dout_n;
        bval <= bval_n;
        lane <= lane_nx;
        if (beat != 3'd7) beat <= beat + 3'd1;
      end
    end
  end

endmodule

// File: doc/bus_rd_pack.md
Name: bus_rd_pack

Overview:
- Read-data assembly stage sitting directly downstream of the bus-control block's external data enables and down-mux steering.
- Collects successive narrow external-memory read beats (8/16/32/64-bit devices) into one 64-bit internal-bus word.
- Tracks byte-lane fill and byte-lane validity, and pulses done when the word is complete.
- Feeds the internal 64-bit read latch used by the GPU, blitter and CPU paths.

Parameters:
- DW, 64, internal bus width in bits; fixed at 64, present for elaboration checks only.
- ACKQ, 0, extra ack-to-capture delay in cycles (0 or 1), matching external data registering.

Ports:
- sys_clk  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a new assembly; sampled only when idle.
- mws  in  2  device width: 0=8-bit, 1=16-bit, 2=32-bit, 3=64-bit; latched at start.
- ba  in  3  starting byte address within the 64-bit word; latched at start.
- ack  in  1  external beat-valid strobe; xd is valid this cycle (ACKQ=0).
- xd  in  64  external data; a narrow device drives the low wb bytes.
- abort  in  1  cancel the assembly in progress.
- busy  out  1  assembly in progress.
- done  out  1  one-cycle pulse when the word is complete.
- dout  out  64  assembled word; held stable from done until the next start.
- bval  out  8  per-lane valid mask for dout; bit k = byte lane k written.
- beat  out  3  count of beats captured in the current assembly.

Behaviour:
- Reset values (asynchronous): busy=0, done=0, dout=0, bval=0, beat=0, state=IDLE.
- Width: wb = 1<<mws bytes.
- Start lane: lane0 = ba with its low mws bits cleared (aligned down).
- States:
  - IDLE: on start=1, latch mws and lane0, clear bval and beat, go to FILL; busy=1 from the next cycle.
  - FILL: on a capture event, write xd[8*wb-1:0] into dout lanes lane..lane+wb-1, set those bval bits, lane+=wb, beat+=1.
    - If the new lane is 8 (wrap out of the word), go to DONE.
    - Lanes below lane0 are not written and keep their prior dout value; bval=0 for them.
  - DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- Capture event: ack in the same cycle (ACKQ=0) or ack delayed one cycle (ACKQ=1).
- Latency: the last capturing ack to done is 1 cycle (ACKQ=0) or 2 cycles (ACKQ=1).
- 64-bit device with ba=0: a single beat completes the word.
- start while busy: ignored. ack while IDLE or DONE: ignored, no state change.
- abort in FILL: return to IDLE next cycle, busy=0, no done; dout and bval keep the partial contents. abort wins over a simultaneous ack.
- abort in IDLE: no effect.
- A pending ACKQ capture is discarded on abort or reset.
- Reset mid-assembly: immediate return to the reset values.
- beat saturates at 7 (it cannot exceed 8 beats by construction).

Optional Feature:
- Macro: BUS_RD_PACK_BIGEND_EN.
- Defined: big-endian lane order (68k view). Logical lane k maps to physical byte 7-k of dout and bval; the first beat lands in the most-significant bytes.
- Undefined: little-endian; logical lane k = dout[8k+7:8k].
- The lane counter, beat and done timing are identical in both builds.

Test Plan:
- 8-bit device, ba=0, eight acks with xd low bytes 11,22,..,88 -> done one cycle after the 8th ack, dout=0x8877665544332211, bval=0xFF, beat=7 saturated.
- 16-bit device, ba=5 -> lane0=4; two acks 0xBBAA, 0xDDCC -> dout[63:32]=0xDDCCBBAA, bval=0xF0, low half unchanged, beat=2.
- 64-bit device, ba=3 -> single ack 0x0123456789ABCDEF gives done next cycle, dout equal to xd, bval=0xFF.
- 32-bit device with abort asserted with the 1st ack -> no capture, busy=0 next cycle, no done; new start then completes normally.
- Reset asserted mid-FILL after 3 byte beats -> outputs return to zero asynchronously; ack during reset is ignored.
- BUS_RD_PACK_BIGEND_EN, 16-bit device, ba=0, four acks 0x0102,0x0304,0x0506,0x0708 -> dout=0x0201040306050807, bval=0xFF.
